pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline-stage register generalising the fixed IF/ID latch: carries a WIDTH-bit payload between any two core stages with a valid/ready handshake in place of a bare enable. Supports flush with bubble insertion and reports occupancy. An optional two-entry skid buffer makes the upstream ready registered without losing throughput. Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

## Interface
- WIDTH, 64, payload width in bits (IF/ID: {pc, instr}).
- RESET_VAL, '0, payload value driven on data_o after reset and after flush.
- clk  input  1  stage clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  upstream has a payload.
- ready_o  output  1  stage can accept; transfer in when valid_i && ready_o.
- data_i  input  WIDTH  upstream payload.
- valid_o  output  1  payload available downstream.
- ready_i  input  1  downstream accepts; transfer out when valid_o && ready_i (replaces ~stall).
- data_o  output  WIDTH  payload to downstream.
- flush_i  input  1  branch/jump/trap flush; kills every held and incoming payload.
- count_o  output  2  entries held (0..2 with skid, 0..1 without).

## Operation
- Reset (rst_n low, asynchronous): valid_o=0, data_o=RESET_VAL, count_o=0, skid empty, ready_o=1.
- Output register: loaded on accept-in when empty, or when draining (valid_o && ready_i) with a new source available.
- Accept-in when output empty or draining: data_i goes to output register next edge.
- Accept-in while output held (valid_o && !ready_i): data_i goes to skid slot (skid build only).
- Drain with skid full: skid moves to output register; a same-cycle accept-in refills skid only if ready_o was 1.
- Order preserved: strict FIFO, no reordering, no duplication, no drop except on flush.
- Flush: synchronous, highest priority over accept and drain. At the edge: valid_o=0, data_o=RESET_VAL, skid cleared, count_o=0. An input presented in the flush cycle is discarded even if ready_o=1. A downstream transfer in the flush cycle still completes (the consumer has already sampled it).
- data_o holds its value while valid_o && !ready_i; it is RESET_VAL whenever valid_o=0 after reset or flush. It is stale, not cleared, after a normal drain.
- count_o = valid_o + skid_valid, registered.

## Timing
- Latency: 1 cycle data_i to data_o when empty; 2 cycles when entering via skid.
- Throughput: 1 transfer/cycle sustained in both builds.
- ready_o with skid: registered, equals !skid_valid; drops the cycle after the skid fills; returns the cycle after the skid drains.
- ready_o without skid: combinational, !valid_o || ready_i (ready_i→ready_o path exists).
- Full boundary (count 2): ready_o=0; valid_i ignored.
- Empty boundary: valid_o=0; ready_i ignored.
- Reset deassertion mid-stream: first accept occurs on the first edge with rst_n high.
- Flush and rst_n low together: reset wins; result is identical.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry storage (output register + skid), registered ready_o, count_o up to 2.
- Undefined: single-entry; skid logic absent; ready_o combinational as above; count_o[1] tied 0.
- Handshake protocol and flush semantics are identical in both builds.

## Structure
- Package core_pipe_pkg: payload typedefs per boundary (if_id_t {pc[31:0], instr[31:0]}, etc.), widths as localparams, BUBBLE constant (RESET_VAL default; 32'h0000_0013 NOP option for instr field).
- Sub-module pipe_skid_slot: one WIDTH-bit register with valid and load/clear controls, instantiated only under PIPE_STAGE_SKID_EN.
- Top module keeps handshake, flush priority and count logic.

## Test plan
- Reset: hold rst_n=0 with valid_i=1 and data_i=0xAAAA → valid_o=0, data_o=RESET_VAL, count_o=0, ready_o=1. Release: next edge gives data_o=0xAAAA, valid_o=1.
- Streaming: valid_i=1 on 8 cycles with data 1..8, ready_i=1 → data_o 1..8 on consecutive cycles, one cycle late, count_o=1 throughout.
- Back-pressure (skid): ready_i=0 while feeding 1,2,3 → count_o=2, ready_o=0 after 2, and 3 is held off upstream. Raise ready_i → output 1,2,3 in order, no loss.
- Back-pressure (no skid): ready_i=0 with 5 held → ready_o=0 in the same cycle. Raise ready_i with 6 valid → 6 accepted that cycle, data_o=6 next.
- Flush with full stage: count_o=2, flush_i=1 with valid_i=1 and data 9 → next cycle valid_o=0, data_o=RESET_VAL, count_o=0; 9 never appears.
- Async reset mid-burst: pull rst_n low between edges → outputs take reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/core_pipe_pkg.sv
// Shared types for the core pipeline boundaries: per-stage payload structs,
// their widths, bubble constants and the stage occupancy encoding.
package core_pipe_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;
    localparam int REG_W   = 5;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [XLEN-1:0]    rs1_val;
        logic [XLEN-1:0]    rs2_val;
        logic [XLEN-1:0]    imm;
        logic [INSTR_W-1:0] instr;
    } id_ex_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [XLEN-1:0]  alu_res;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
        logic             mem_rd;
        logic             mem_wr;
        logic             wb_en;
    } ex_mem_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [XLEN-1:0]  wb_data;
        logic [REG_W-1:0] rd;
        logic             wb_en;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // addi x0, x0, 0: lets a flushed IF/ID slot decode as a harmless NOP
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [IF_ID_W-1:0] BUBBLE       = '0;
    localparam if_id_t             IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic occ_e occupancy(input logic out_valid, input logic skid_valid);
        logic [1:0] sum;
        sum = {1'b0, out_valid} + {1'b0, skid_valid};
        return occ_e'(sum);
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// Single payload slot with valid bit; clear has priority over load so a
// flush always empties the slot.
module pipe_skid_slot #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and occupancy count.
// Define PIPE_STAGE_SKID_EN for the two-entry build with registered ready_o.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    input  logic             flush_i,
    output logic [1:0]       count_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    occ_e             count_q, count_d;
    logic             accept;
    logic             drain;
    logic             skid_valid_d;

    assign accept = valid_i && ready_o;
    assign drain  = valid_q && ready_i;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_load;
    logic             skid_clear;

    // ready_o is just the inverted skid flag, so it comes straight off a flop
    assign ready_o = !skid_valid;

    pipe_skid_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (data_i),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush_i) begin
            valid_d    = 1'b0;
            data_d     = RESET_VAL;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            if (drain) begin
                data_d     = skid_data;
                skid_clear = 1'b1;
            end
        end else if (accept) begin
            if (!valid_q || drain) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end else begin
                skid_load = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    assign skid_valid_d = skid_clear ? 1'b0 : (skid_load ? 1'b1 : skid_valid);
`else
    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    assign skid_valid_d = 1'b0;
`endif

    assign count_d = occupancy(valid_d, skid_valid_d);

    // A normal drain only drops valid; data_q keeps the stale payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
            count_q <= OCC_EMPTY;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps then random traffic,
// compared against a FIFO-queue reference of the stage contents.
module tb_pipe_stage_reg;

    localparam int          W  = 64;
    localparam logic [W-1:0] RV = 64'hDEAD_0000_0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         flush_i;
    logic [1:0]   count_o;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] modelQ[$];
    logic [W-1:0] lastOut;

    pipe_stage_reg #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .flush_i (flush_i),
        .count_o (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelReady(input logic r);
        if (SKID) return modelQ.size() < 2;
        return (modelQ.size() == 0) || r;
    endfunction

    task automatic modelReset();
        modelQ.delete();
        lastOut = RV;
    endtask

    task automatic checkOutput(input string tag);
        logic         expValid;
        logic [W-1:0] expData;
        logic [1:0]   expCount;
        logic         expReady;
        expValid = modelQ.size() > 0;
        expData  = expValid ? modelQ[0] : lastOut;
        expCount = 2'(modelQ.size());
        expReady = modelReady(ready_i);
        checks++;
        assert (valid_o === expValid) else begin
            errors++;
            $error("[TB] FAIL %s valid_o got=%0b exp=%0b", tag, valid_o, expValid);
        end
        checks++;
        assert (data_o === expData) else begin
            errors++;
            $error("[TB] FAIL %s data_o got=%h exp=%h", tag, data_o, expData);
        end
        checks++;
        assert (count_o === expCount) else begin
            errors++;
            $error("[TB] FAIL %s count_o got=%0d exp=%0d", tag, count_o, expCount);
        end
        checks++;
        assert (ready_o === expReady) else begin
            errors++;
            $error("[TB] FAIL %s ready_o got=%0b exp=%0b", tag, ready_o, expReady);
        end
    endtask

    // Called just after a rising edge: drive, check, advance model, wait an edge
    task automatic applyStimulus(input logic v, input logic [W-1:0] d,
                                 input logic r, input logic f, input string tag);
        logic rdy;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        #1;
        checkOutput(tag);
        rdy = modelReady(r);
        if (f) begin
            modelReset();
        end else begin
            if (modelQ.size() > 0 && r) lastOut = modelQ.pop_front();
            if (v && rdy) modelQ.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b1;
        data_i  = 64'hAAAA;
        ready_i = 1'b0;
        flush_i = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");

        rst_n = 1'b1;
        applyStimulus(1'b1, 64'hAAAA, 1'b0, 1'b0, "release");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "releaseData");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "idle");

        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, W'(i), 1'b1, 1'b0, "stream");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "streamTail");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "streamStale");

        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0, "backPressure");
        applyStimulus(1'b1, 64'd3, 1'b0, 1'b0, "heldOff");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "bpDrain");

        applyStimulus(1'b1, 64'd5, 1'b0, 1'b0, "hold5");
        applyStimulus(1'b1, 64'd6, 1'b0, 1'b0, "stall6");
        applyStimulus(1'b1, 64'd6, 1'b1, 1'b0, "accept6");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "out6");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, "stale6");

        applyStimulus(1'b1, 64'd10, 1'b0, 1'b0, "fill10");
        applyStimulus(1'b1, 64'd11, 1'b0, 1'b0, "fill11");
        applyStimulus(1'b1, 64'd9, 1'b0, 1'b1, "flushFull");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "afterFlush");
        applyStimulus(1'b1, 64'd12, 1'b1, 1'b0, "refill");
        applyStimulus(1'b1, 64'd13, 1'b1, 1'b1, "flushDrain");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "afterFlush2");

        for (int i = 20; i < 24; i++) applyStimulus(1'b1, W'(i), i[0], 1'b0, "burst");
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 64'd30, 1'b1, 1'b1, "resetAndFlush");
        rst_n = 1'b1;
        applyStimulus(1'b1, 64'd31, 1'b0, 1'b0, "firstAccept");

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "random");
        end
        checkOutput("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
